// File: rtl/host_descriptor_dispatch.sv
// host_descriptor_dispatch
//   Consumer end of the host transmit descriptor interface. Takes one 24-bit
//   descriptor at a time, requests that packet from the packet buffer by
//   bufid, forwards its beats to the host port with one register stage, then
//   returns the bufid to the free-pointer pool. One packet in flight.
//
//   Optional XFER watchdog: define HOST_DISPATCH_TIMEOUT_EN. When a packet
//   receives no beat for TIMEOUT_CYCLES consecutive XFER cycles, its bufid is
//   released without a tail and ov_abort_cnt increments. Without the macro,
//   XFER waits for a tail indefinitely and ov_abort_cnt is tied to 0.
//
// Ports
//   i_clk, i_rst                         clock, synchronous active-high reset
//   iv_descriptor / i_descriptor_wr      descriptor in ([23:9] meta, [8:0] bufid)
//   o_descriptor_ready                   high only while IDLE
//   ov_pkt_bufid / o_pkt_rd_req          packet read request, held until i_pkt_rd_ack
//   iv_pkt_data / i_pkt_data_wr          beats from packet buffer ([133:132] flag)
//   ov_data / o_data_wr                  beats to host port, 1-cycle latency
//   ov_flow_meta                         metadata of the latest accepted descriptor
//   ov_bufid_release / o_bufid_release_wr  release request, held until i_bufid_release_ack
//   ov_tx_pkt_cnt, ov_abort_cnt          16-bit wrapping event counters
module host_descriptor_dispatch #(
    parameter int unsigned DATA_WIDTH     = 134,
    parameter int unsigned BUFID_WIDTH    = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [23:0]            iv_descriptor,
    input  logic                   i_descriptor_wr,
    output logic                   o_descriptor_ready,
    output logic [BUFID_WIDTH-1:0] ov_pkt_bufid,
    output logic                   o_pkt_rd_req,
    input  logic                   i_pkt_rd_ack,
    input  logic [DATA_WIDTH-1:0]  iv_pkt_data,
    input  logic                   i_pkt_data_wr,
    output logic [DATA_WIDTH-1:0]  ov_data,
    output logic                   o_data_wr,
    output logic [23-BUFID_WIDTH:0] ov_flow_meta,
    output logic [BUFID_WIDTH-1:0] ov_bufid_release,
    output logic                   o_bufid_release_wr,
    input  logic                   i_bufid_release_ack,
    output logic [15:0]            ov_tx_pkt_cnt,
    output logic [15:0]            ov_abort_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    state_t                    state, state_nxt;
    logic [BUFID_WIDTH-1:0]    bufid;
    logic [23-BUFID_WIDTH:0]   meta;
    logic [DATA_WIDTH-1:0]     data;
    logic                      data_wr;
    logic [15:0]               tx_cnt;
    logic                      beat_in;
    logic                      tail_in;
    logic                      timeout;
    logic                      aborted;

    // Only beats arriving in XFER are forwarded; the flag MSB marks a tail (10 or 11).
    assign beat_in = (state == XFER) && i_pkt_data_wr;
    assign tail_in = beat_in && iv_pkt_data[DATA_WIDTH-1];

`ifdef HOST_DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic [15:0]   abort_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive beat-less XFER cycle.
    assign timeout = (state == XFER) && !i_pkt_data_wr &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt  <= '0;
            abort_cnt <= '0;
            aborted   <= 1'b0;
        end else begin
            if (state != XFER || i_pkt_data_wr || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
            if (timeout) begin
                abort_cnt <= abort_cnt + 16'd1;
                aborted   <= 1'b1;
            end else if (state == IDLE) begin
                aborted   <= 1'b0;
            end
        end
    end

    assign ov_abort_cnt = abort_cnt;
`else
    assign timeout      = 1'b0;
    assign aborted      = 1'b0;
    assign ov_abort_cnt = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_descriptor_wr)     state_nxt = REQ;
            REQ:     if (i_pkt_rd_ack)        state_nxt = XFER;
            XFER:    if (tail_in || timeout)  state_nxt = RELEASE;
            RELEASE: if (i_bufid_release_ack) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_descriptor_ready = (state == IDLE);
        o_pkt_rd_req       = (state == REQ);
        o_bufid_release_wr = (state == RELEASE);
        ov_pkt_bufid       = (state == REQ)     ? bufid : '0;
        ov_bufid_release   = (state == RELEASE) ? bufid : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bufid   <= '0;
            meta    <= '0;
            data    <= '0;
            data_wr <= 1'b0;
            tx_cnt  <= '0;
        end else begin
            if (state == IDLE && i_descriptor_wr)
                {meta, bufid} <= iv_descriptor;
            data_wr <= beat_in;
            if (beat_in)
                data <= iv_pkt_data;
            if (state == RELEASE && i_bufid_release_ack && !aborted)
                tx_cnt <= tx_cnt + 16'd1;
        end
    end

    assign ov_data       = data;
    assign o_data_wr     = data_wr;
    assign ov_flow_meta  = meta;
    assign ov_tx_pkt_cnt = tx_cnt;

endmodule
